// File: rtl/pwm_csr_bank_pkg.sv
// Shared encodings for the PWM command decoder and channel bank.
// Register indices, command bit fields and decoder states.
package pwm_csr_bank_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI
  } state_t;

  localparam logic [1:0] REG_DUTY   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam logic [7:0] ID_MAGIC = 8'hA5;

  localparam int CMD_WR     = 7;
  localparam int CMD_CH_MSB = 4;
  localparam int CMD_CH_LSB = 2;
  localparam int CMD_RG_MSB = 1;
  localparam int CMD_RG_LSB = 0;

endpackage

// File: rtl/pwm_csr_bank_channel.sv
// One PWM channel: shadow/active duty+period, counter, compare, invert.
// Shadow values move to active only when the counter wraps.
module pwm_channel
  import pwm_csr_bank_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [1:0]    wr_reg,
  input  logic [CW-1:0] wr_data,
  input  logic [1:0]    rd_reg,
  output logic [15:0]   rd_data,
  output logic          pwm
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] duty_sh;
  logic [CW-1:0] per_sh;
  logic [CW-1:0] duty_act;
  logic [CW-1:0] per_act;
  logic          en;
  logic          inv;
  logic          wrap;
  logic          raw;

  assign wrap = (per_act == '0) || (cnt == per_act - ONE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      duty_sh  <= '0;
      per_sh   <= '0;
      duty_act <= '0;
      per_act  <= '0;
      en       <= 1'b0;
      inv      <= 1'b0;
    end else begin
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + ONE;
      if (wrap) begin
        duty_act <= duty_sh;
        per_act  <= per_sh;
      end
      if (wr_en) begin
        unique case (1'b1)
          wr_reg == REG_DUTY:   duty_sh <= wr_data;
          wr_reg == REG_PERIOD: per_sh  <= wr_data;
          wr_reg == REG_CTRL: begin
            en  <= wr_data[0];
            inv <= wr_data[1];
          end
          default: ;
        endcase
      end
    end
  end

  // a zero period never lets the output assert
  assign raw = en && (per_act != '0) && (cnt < duty_act);
  assign pwm = raw ^ inv;

  always_comb begin
    rd_data = '0;
    case (rd_reg)
      REG_DUTY:   rd_data[CW-1:0] = duty_sh;
      REG_PERIOD: rd_data[CW-1:0] = per_sh;
      REG_CTRL:   rd_data[1:0]    = {inv, en};
      default:    rd_data         = '0;
    endcase
  end

endmodule

// File: rtl/pwm_csr_bank.sv
// SPI byte-stream command decoder and register bank for N_CH PWM channels.
// Command byte then 16-bit words LSB-first, auto-increment within a channel.
module pwm_csr_bank
  import pwm_csr_bank_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = 16
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic [7:0]      data_in,
  input  logic            data_rdy,
  input  logic            frame,
  output logic [7:0]      data_out,
  output logic            data_latch,
  output logic            addr_err,
  output logic [N_CH-1:0] pwm_out
);

  localparam logic [15:0] ID_WORD = {ID_MAGIC, 5'b0, 3'(N_CH - 1)};

  function automatic logic ch_ok(input logic [2:0] ch);
    return {1'b0, ch} < 4'(N_CH);
  endfunction

  state_t      state;
  state_t      state_n;
  logic        rdy_q;
  logic        accept;
  logic [2:0]  ch_q;
  logic [2:0]  ch_n;
  logic [1:0]  reg_q;
  logic [1:0]  reg_n;
  logic [7:0]  lsb_q;
  logic [7:0]  lsb_n;
  logic [7:0]  dout_n;
  logic        latch_n;
  logic        aerr_n;
  logic        wr_stb;
  logic [15:0] wr_word;

  logic        cmd_wr;
  logic [2:0]  cmd_ch;
  logic [1:0]  cmd_rg;

  logic [2:0]  rd_ch;
  logic [1:0]  rd_sel;
  logic [15:0] rd_word;
  logic [15:0] rd_val [8];

  assign accept  = data_rdy && !rdy_q && frame;
  assign cmd_wr  = data_in[CMD_WR];
  assign cmd_ch  = data_in[CMD_CH_MSB:CMD_CH_LSB];
  assign cmd_rg  = data_in[CMD_RG_MSB:CMD_RG_LSB];
  assign wr_word = {data_in, lsb_q};

  // in IDLE the read target comes straight from the command byte
  assign rd_ch  = (state == S_IDLE) ? cmd_ch : ch_q;
  assign rd_sel = (state == S_IDLE) ? cmd_rg : reg_q;

  always_comb begin
    rd_word = '0;
    if (ch_ok(rd_ch)) begin
      if (rd_sel == REG_ID) rd_word = ID_WORD;
      else                  rd_word = rd_val[rd_ch];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rdy_q      <= 1'b0;
      ch_q       <= '0;
      reg_q      <= '0;
      lsb_q      <= '0;
      data_out   <= '0;
      data_latch <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_n;
      rdy_q      <= data_rdy;
      ch_q       <= ch_n;
      reg_q      <= reg_n;
      lsb_q      <= lsb_n;
      data_out   <= dout_n;
      data_latch <= latch_n;
      addr_err   <= aerr_n;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch_q;
    reg_n   = reg_q;
    lsb_n   = lsb_q;
    dout_n  = data_out;
    latch_n = 1'b0;
    aerr_n  = 1'b0;
    wr_stb  = 1'b0;
    if (!frame) begin
      state_n = S_IDLE;
    end else if (accept) begin
      unique case (state)
        S_IDLE: begin
          ch_n   = cmd_ch;
          reg_n  = cmd_rg;
          aerr_n = !ch_ok(cmd_ch);
          if (cmd_wr) begin
            state_n = S_WR_LO;
          end else begin
            dout_n  = rd_word[7:0];
            latch_n = 1'b1;
            state_n = S_RD_HI;
          end
        end
        S_WR_LO: begin
          lsb_n   = data_in;
          state_n = S_WR_HI;
        end
        S_WR_HI: begin
          wr_stb  = ch_ok(ch_q) && (reg_q != REG_ID);
          reg_n   = reg_q + 2'd1;
          state_n = S_WR_LO;
        end
        S_RD_HI: begin
          dout_n  = rd_word[15:8];
          latch_n = 1'b1;
          reg_n   = reg_q + 2'd1;
          state_n = S_RD_LO;
        end
        S_RD_LO: begin
          dout_n  = rd_word[7:0];
          latch_n = 1'b1;
          state_n = S_RD_HI;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < N_CH) begin : g_ch
      pwm_channel #(
        .CW (CW)
      ) u_ch (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_stb && (ch_q == 3'(g))),
        .wr_reg  (reg_q),
        .wr_data (wr_word[CW-1:0]),
        .rd_reg  (rd_sel),
        .rd_data (rd_val[g]),
        .pwm     (pwm_out[g])
      );
    end else begin : g_nc
      assign rd_val[g] = '0;
    end
  end

endmodule
